dpll_control_mc: RTL and testbench

Top-level DPLL search controller for the SAT accelerator. It generalises the single-core control FSM to NUM_BCP parallel BCP channels by splitting each variable's clause range into per-channel slices. It drives the decide / propagate / backtrack loop over the imply stack, trace stack, var-state table and var start-end (VSE) table, and reports sat/unsat plus a conflict counter.

---
 rtl/dpll_control_mc.sv | 250 +++++++++++++++++++++++++
 tb/tb_dpll_control_mc.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpll_control_mc.sv
// DPLL search controller: decide / propagate / backtrack over the imply and trace
// stacks, fanning each variable's clause range out across NUM_BCP propagation channels.
module dpll_control_mc #(
  parameter int   VAR_BITS    = 8,
  parameter int   CLAUSE_BITS = 10,
  parameter int   NUM_BCP     = 4,
  parameter int   CNT_BITS    = 16,
  parameter logic DEFAULT_POL = 1'b1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  output logic                           sat,
  output logic                           unsat,
  input  logic                           unassigned_valid,
  input  logic [VAR_BITS-1:0]            unassigned_var,
  output logic                           read_vse,
  input  logic [CLAUSE_BITS-1:0]         start_clause,
  input  logic [CLAUSE_BITS-1:0]         end_clause,
  output logic [NUM_BCP-1:0]             bcp_start,
  output logic [VAR_BITS-1:0]            bcp_var,
  output logic                           bcp_val,
  output logic [NUM_BCP*CLAUSE_BITS-1:0] bcp_lo,
  output logic [NUM_BCP*CLAUSE_BITS-1:0] bcp_hi,
  input  logic [NUM_BCP-1:0]             bcp_busy,
  input  logic [NUM_BCP-1:0]             bcp_conflict,
  input  logic                           empty_imply,
  input  logic [VAR_BITS-1:0]            var_out_imply,
  input  logic                           val_out_imply,
  output logic                           pop_imply,
  output logic                           flush_imply,
  input  logic                           empty_trace,
  input  logic [VAR_BITS-1:0]            var_out_trace,
  input  logic                           val_out_trace,
  input  logic                           type_out_trace,
  output logic                           pop_trace,
  output logic                           push_trace,
  output logic                           type_in_trace,
  output logic                           write_vs,
  output logic [VAR_BITS-1:0]            var_in_vs,
  output logic                           val_in_vs,
  output logic                           unassign_in_vs,
  output logic                           clear_state,
  output logic [CNT_BITS-1:0]            conflict_count,
  output logic [3:0]                     dbg_state
);

  // Handshake: every strobe is registered and high for exactly one cycle; a
  // BCP channel's conflict flag is only trusted once its busy line is low.
  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_DECIDE, S_LOOKUP, S_DISPATCH, S_WAIT0,
    S_WAIT, S_IMPLY, S_BACKTRACK, S_FLIP, S_SAT, S_UNSAT
  } state_t;

  localparam int SH = $clog2(NUM_BCP);
  localparam int WW = CLAUSE_BITS + SH + 2;

  state_t                     state_q;
  logic                       sat_q, unsat_q, read_vse_q, clear_q;
  logic [NUM_BCP-1:0]         bcp_start_q, started_q;
  logic [VAR_BITS-1:0]        bcp_var_q, var_in_q;
  logic                       bcp_val_q, val_in_q, unassign_q, type_in_q;
  logic [NUM_BCP*CLAUSE_BITS-1:0] lo_q, hi_q, lo_d, hi_d;
  logic                       pop_imply_q, flush_q, pop_trace_q, push_trace_q, write_vs_q;
  logic [CNT_BITS-1:0]        cnt_q;
  logic [NUM_BCP-1:0]         mask_d;
  logic [CLAUSE_BITS:0]       len_d;
  logic [WW-1:0]              per_w, lo_w, hi_w, end_w;

  // Slice the inclusive range [start, end] into NUM_BCP chunks of ceil(len/NUM_BCP).
  always_comb begin
    len_d  = {1'b0, end_clause} - {1'b0, start_clause} + (CLAUSE_BITS+1)'(1);
    per_w  = (WW'(len_d) + WW'(NUM_BCP - 1)) >> SH;
    end_w  = WW'(end_clause);
    lo_w   = '0;
    hi_w   = '0;
    mask_d = '0;
    lo_d   = '0;
    hi_d   = '0;
    for (int i = 0; i < NUM_BCP; i++) begin
      lo_w = WW'(start_clause) + WW'(i) * per_w;
      hi_w = lo_w + per_w - WW'(1);
      if (hi_w > end_w) hi_w = end_w;
      mask_d[i] = (lo_w <= end_w);
      lo_d[i*CLAUSE_BITS +: CLAUSE_BITS] = lo_w[CLAUSE_BITS-1:0];
      hi_d[i*CLAUSE_BITS +: CLAUSE_BITS] = hi_w[CLAUSE_BITS-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      sat_q        <= 1'b0;
      unsat_q      <= 1'b0;
      read_vse_q   <= 1'b0;
      clear_q      <= 1'b0;
      bcp_start_q  <= '0;
      started_q    <= '0;
      bcp_var_q    <= '0;
      bcp_val_q    <= 1'b0;
      var_in_q     <= '0;
      val_in_q     <= 1'b0;
      unassign_q   <= 1'b0;
      type_in_q    <= 1'b0;
      lo_q         <= '0;
      hi_q         <= '0;
      pop_imply_q  <= 1'b0;
      flush_q      <= 1'b0;
      pop_trace_q  <= 1'b0;
      push_trace_q <= 1'b0;
      write_vs_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      read_vse_q   <= 1'b0;
      clear_q      <= 1'b0;
      bcp_start_q  <= '0;
      pop_imply_q  <= 1'b0;
      flush_q      <= 1'b0;
      pop_trace_q  <= 1'b0;
      push_trace_q <= 1'b0;
      write_vs_q   <= 1'b0;
      case (state_q)
        S_IDLE, S_SAT, S_UNSAT: begin
          if (start) begin
            sat_q   <= 1'b0;
            unsat_q <= 1'b0;
            cnt_q   <= '0;
            clear_q <= 1'b1;
            state_q <= S_INIT;
          end
        end
        S_INIT: state_q <= S_DECIDE;
        S_DECIDE: begin
          if (!unassigned_valid) begin
            sat_q   <= 1'b1;
            state_q <= S_SAT;
          end else begin
            write_vs_q   <= 1'b1;
            push_trace_q <= 1'b1;
            type_in_q    <= 1'b1;
            var_in_q     <= unassigned_var;
            val_in_q     <= DEFAULT_POL;
            unassign_q   <= 1'b0;
            bcp_var_q    <= unassigned_var;
            bcp_val_q    <= DEFAULT_POL;
            read_vse_q   <= 1'b1;
            state_q      <= S_LOOKUP;
          end
        end
        S_LOOKUP: state_q <= S_DISPATCH;
        S_DISPATCH: begin
          if (end_clause < start_clause) begin
            state_q <= S_IMPLY;
          end else begin
            bcp_start_q <= mask_d;
            started_q   <= mask_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            state_q     <= S_WAIT0;
          end
        end
        S_WAIT0: state_q <= S_WAIT;
        S_WAIT: begin
          if ((bcp_busy & started_q) == '0) begin
            if ((bcp_conflict & started_q) != '0) begin
              flush_q <= 1'b1;
              if (cnt_q != '1) cnt_q <= cnt_q + CNT_BITS'(1);
              state_q <= S_BACKTRACK;
            end else begin
              state_q <= S_IMPLY;
            end
          end
        end
        S_IMPLY: begin
          if (empty_imply) begin
            state_q <= S_DECIDE;
          end else begin
            pop_imply_q  <= 1'b1;
            write_vs_q   <= 1'b1;
            push_trace_q <= 1'b1;
            type_in_q    <= 1'b0;
            var_in_q     <= var_out_imply;
            val_in_q     <= val_out_imply;
            unassign_q   <= 1'b0;
            bcp_var_q    <= var_out_imply;
            bcp_val_q    <= val_out_imply;
            read_vse_q   <= 1'b1;
            state_q      <= S_LOOKUP;
          end
        end
        S_BACKTRACK: begin
          // The trace top is stale while a pop issued last cycle is still landing.
          if (!pop_trace_q) begin
            if (empty_trace) begin
              unsat_q <= 1'b1;
              state_q <= S_UNSAT;
            end else if (!type_out_trace) begin
              pop_trace_q <= 1'b1;
              write_vs_q  <= 1'b1;
              var_in_q    <= var_out_trace;
              val_in_q    <= val_out_trace;
              unassign_q  <= 1'b1;
            end else begin
              pop_trace_q <= 1'b1;
              write_vs_q  <= 1'b1;
              var_in_q    <= var_out_trace;
              val_in_q    <= ~val_out_trace;
              unassign_q  <= 1'b0;
              bcp_var_q   <= var_out_trace;
              bcp_val_q   <= ~val_out_trace;
              state_q     <= S_FLIP;
            end
          end
        end
        S_FLIP: begin
          push_trace_q <= 1'b1;
          type_in_q    <= 1'b0;
          var_in_q     <= bcp_var_q;
          val_in_q     <= bcp_val_q;
          unassign_q   <= 1'b0;
          read_vse_q   <= 1'b1;
          state_q      <= S_LOOKUP;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sat            = sat_q;
  assign unsat          = unsat_q;
  assign read_vse       = read_vse_q;
  assign bcp_start      = bcp_start_q;
  assign bcp_var        = bcp_var_q;
  assign bcp_val        = bcp_val_q;
  assign bcp_lo         = lo_q;
  assign bcp_hi         = hi_q;
  assign pop_imply      = pop_imply_q;
  assign flush_imply    = flush_q;
  assign pop_trace      = pop_trace_q;
  assign push_trace     = push_trace_q;
  assign type_in_trace  = type_in_q;
  assign write_vs       = write_vs_q;
  assign var_in_vs      = var_in_q;
  assign val_in_vs      = val_in_q;
  assign unassign_in_vs = unassign_q;
  assign clear_state    = clear_q;
  assign conflict_count = cnt_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_dpll_control_mc.sv
// Bench for dpll_control_mc: behavioural stacks, var-state, VSE and BCP channels around
// the controller; expected strobe events are queued per scenario and popped by a monitor.
module tb_dpll_control_mc;
  localparam int VB = 8;
  localparam int CB = 10;
  localparam int NB = 4;
  localparam int CW = 2;

  logic clock, reset, start;
  logic sat, unsat, unassigned_valid, read_vse, bcp_val;
  logic [VB-1:0] unassigned_var, bcp_var, var_out_imply, var_out_trace, var_in_vs;
  logic [CB-1:0] start_clause, end_clause;
  logic [NB-1:0] bcp_start, bcp_busy, bcp_conflict;
  logic [NB*CB-1:0] bcp_lo, bcp_hi;
  logic empty_imply, val_out_imply, pop_imply, flush_imply;
  logic empty_trace, val_out_trace, type_out_trace, pop_trace, push_trace, type_in_trace;
  logic write_vs, val_in_vs, unassign_in_vs, clear_state;
  logic [CW-1:0] conflict_count;
  logic [3:0] dbg_state;

  dpll_control_mc #(.VAR_BITS(VB), .CLAUSE_BITS(CB), .NUM_BCP(NB), .CNT_BITS(CW),
                    .DEFAULT_POL(1'b1)) dut (
    .clock(clock), .reset(reset), .start(start), .sat(sat), .unsat(unsat),
    .unassigned_valid(unassigned_valid), .unassigned_var(unassigned_var),
    .read_vse(read_vse), .start_clause(start_clause), .end_clause(end_clause),
    .bcp_start(bcp_start), .bcp_var(bcp_var), .bcp_val(bcp_val),
    .bcp_lo(bcp_lo), .bcp_hi(bcp_hi), .bcp_busy(bcp_busy), .bcp_conflict(bcp_conflict),
    .empty_imply(empty_imply), .var_out_imply(var_out_imply), .val_out_imply(val_out_imply),
    .pop_imply(pop_imply), .flush_imply(flush_imply),
    .empty_trace(empty_trace), .var_out_trace(var_out_trace), .val_out_trace(val_out_trace),
    .type_out_trace(type_out_trace), .pop_trace(pop_trace), .push_trace(push_trace),
    .type_in_trace(type_in_trace), .write_vs(write_vs), .var_in_vs(var_in_vs),
    .val_in_vs(val_in_vs), .unassign_in_vs(unassign_in_vs), .clear_state(clear_state),
    .conflict_count(conflict_count), .dbg_state(dbg_state));

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- environment tables ----------------
  logic [255:0] live, asg;
  logic [CB-1:0] vse_s [0:255];
  logic [CB-1:0] vse_e [0:255];
  logic [NB-1:0] conf_mask [0:511];
  logic          imp_v [0:511];
  logic [VB-1:0] imp_var [0:511];
  logic          imp_val [0:511];
  int            lat;

  logic [VB-1:0] tr_var [0:63];
  logic          tr_val [0:63];
  logic          tr_typ [0:63];
  int            tsp;
  logic [VB-1:0] im_var [0:63];
  logic          im_val [0:63];
  int            isp;
  int            bcnt [0:NB-1];
  logic [NB-1:0] bcf;

  always_comb begin
    unassigned_valid = 1'b0;
    unassigned_var   = '0;
    for (int v = 15; v >= 0; v--)
      if (live[v] && !asg[v]) begin
        unassigned_valid = 1'b1;
        unassigned_var   = VB'(v);
      end
    empty_imply    = (isp == 0);
    var_out_imply  = (isp > 0) ? im_var[isp-1] : '0;
    val_out_imply  = (isp > 0) ? im_val[isp-1] : 1'b0;
    empty_trace    = (tsp == 0);
    var_out_trace  = (tsp > 0) ? tr_var[tsp-1] : '0;
    val_out_trace  = (tsp > 0) ? tr_val[tsp-1] : 1'b0;
    type_out_trace = (tsp > 0) ? tr_typ[tsp-1] : 1'b0;
    for (int i = 0; i < NB; i++) bcp_busy[i] = (bcnt[i] != 0);
    bcp_conflict = bcf & ~bcp_busy;
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      asg <= '0; tsp <= 0; isp <= 0; bcf <= '0;
      start_clause <= '0; end_clause <= '0;
      for (int i = 0; i < NB; i++) bcnt[i] <= 0;
    end else begin
      int n;
      int m;
      if (read_vse) begin
        start_clause <= vse_s[bcp_var];
        end_clause   <= vse_e[bcp_var];
      end
      for (int i = 0; i < NB; i++) begin
        if (bcp_start[i]) begin
          bcnt[i] <= lat;
          bcf[i]  <= conf_mask[{bcp_var, bcp_val}][i];
        end else if (bcnt[i] != 0) bcnt[i] <= bcnt[i] - 1;
      end
      if (clear_state) begin
        asg <= '0; tsp <= 0; isp <= 0;
      end else begin
        if (write_vs) asg[var_in_vs] <= !unassign_in_vs;
        n = tsp;
        if (pop_trace) n = n - 1;
        if (push_trace) begin
          tr_var[n] <= var_in_vs; tr_val[n] <= val_in_vs; tr_typ[n] <= type_in_trace;
          n = n + 1;
        end
        tsp <= n;
        m = flush_imply ? 0 : isp;
        if (pop_imply) m = m - 1;
        if (bcp_start[0] && conf_mask[{bcp_var, bcp_val}] == '0 && imp_v[{bcp_var, bcp_val}]) begin
          im_var[m] <= imp_var[{bcp_var, bcp_val}];
          im_val[m] <= imp_val[{bcp_var, bcp_val}];
          m = m + 1;
        end
        isp <= m;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [95:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [95:0] ev(input logic [3:0] k, input logic [91:0] p);
    return {k, p};
  endfunction

  task automatic e_wr(input int v, input logic b, input logic u);
    exp_q.push_back(ev(4'd1, {82'd0, u, b, VB'(v)}));
  endtask
  task automatic e_push(input int v, input logic b, input logic t);
    exp_q.push_back(ev(4'd2, {82'd0, t, b, VB'(v)}));
  endtask
  task automatic e_k(input logic [3:0] k);
    exp_q.push_back(ev(k, 92'd0));
  endtask
  task automatic e_bcp(input logic [3:0] m, input logic [79:0] sl);
    exp_q.push_back(ev(4'd6, {m, 8'd0, sl}));
  endtask
  task automatic e_bcp1(input int lo);
    e_bcp(4'b0001, {60'd0, CB'(lo), CB'(lo)});
  endtask

  task automatic pop_cmp(input string name, input logic [95:0] got);
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: unexpected event %h, expected none", name, got);
    end else check(name, 128'(got), 128'(exp_q.pop_front()));
  endtask

  logic sat_p, unsat_p;
  always @(negedge clock) begin
    if (reset) begin
      logic [79:0] sl;
      if (write_vs) pop_cmp("ev_write_vs",
        ev(4'd1, {82'd0, unassign_in_vs, unassign_in_vs ? 1'b0 : val_in_vs, var_in_vs}));
      if (push_trace) pop_cmp("ev_push_trace", ev(4'd2, {82'd0, type_in_trace, val_in_vs, var_in_vs}));
      if (pop_trace)   pop_cmp("ev_pop_trace", ev(4'd3, 92'd0));
      if (pop_imply)   pop_cmp("ev_pop_imply", ev(4'd4, 92'd0));
      if (flush_imply) pop_cmp("ev_flush_imply", ev(4'd5, 92'd0));
      if (bcp_start != '0) begin
        sl = '0;
        for (int i = 0; i < NB; i++)
          if (bcp_start[i]) sl[i*20 +: 20] = {bcp_lo[i*CB +: CB], bcp_hi[i*CB +: CB]};
        pop_cmp("ev_bcp_start", ev(4'd6, {bcp_start, 8'd0, sl}));
      end
      if (sat && !sat_p)     pop_cmp("ev_sat", ev(4'd7, 92'd0));
      if (unsat && !unsat_p) pop_cmp("ev_unsat", ev(4'd8, 92'd0));
    end
    sat_p   = sat;
    unsat_p = unsat;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_tables();
    live = '0;
    lat  = 2;
    for (int v = 0; v < 256; v++) begin vse_s[v] = '0; vse_e[v] = '0; end
    for (int l = 0; l < 512; l++) begin
      conf_mask[l] = '0; imp_v[l] = 1'b0; imp_var[l] = '0; imp_val[l] = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic run(input string name, input logic want_unsat, input int want_cnt);
    int n;
    pulse_start();
    @(negedge clock);
    check({name, "_cleared_on_start"}, {clear_state, sat, unsat, conflict_count}, {1'b1, 1'b0, 1'b0, CW'(0)});
    n = 0;
    while (!(sat || unsat) && n < 400) begin @(negedge clock); n++; end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no sat/unsat after %0d cycles, required one", name, n);
    end
    repeat (4) @(negedge clock);
    check({name, "_result_held"}, {sat, unsat}, {!want_unsat, want_unsat});
    check({name, "_conflict_count"}, conflict_count, want_cnt);
    check({name, "_events_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset = 1'b0;
    start = 1'b0;
    clear_tables();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_outputs", {sat, unsat, read_vse, bcp_start, bcp_var, bcp_val, bcp_lo, bcp_hi,
          pop_imply, flush_imply, pop_trace, push_trace, type_in_trace, write_vs, var_in_vs,
          val_in_vs, unassign_in_vs, clear_state, conflict_count, dbg_state}, 128'd0);
    @(posedge clock); #1 reset = 1'b1;

    // Reset asserted while channels are busy: outputs drop inside the cycle.
    clear_tables();
    live[1] = 1'b1; vse_s[1] = 10'd0; vse_e[1] = 10'd3; lat = 20;
    e_wr(1, 1'b1, 1'b0); e_push(1, 1'b1, 1'b1);
    e_bcp(4'b1111, {10'd3, 10'd3, 10'd2, 10'd2, 10'd1, 10'd1, 10'd0, 10'd0});
    pulse_start();
    n = 0;
    while (dbg_state != 4'd6 && n < 50) begin @(negedge clock); n++; end
    check("reached_wait", {28'd0, (n < 50)}, 1);
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    #1 check("reset_mid_wait", {sat, unsat, read_vse, bcp_start, bcp_var, bcp_val, bcp_lo, bcp_hi,
          pop_imply, flush_imply, pop_trace, push_trace, type_in_trace, write_vs, var_in_vs,
          val_in_vs, unassign_in_vs, clear_state, conflict_count, dbg_state}, 128'd0);
    check("wait_events_seen", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clock); #1 reset = 1'b1;

    // No variables: SAT three cycles after start, clear_state for exactly one cycle.
    clear_tables();
    e_k(4'd7);
    pulse_start();
    @(negedge clock);
    check("clear_state_c1", {clear_state, sat}, {1'b1, 1'b0});
    @(negedge clock);
    check("clear_state_c2", {clear_state, sat}, {1'b0, 1'b0});
    @(negedge clock);
    check("sat_at_c3", sat, 1);
    repeat (6) @(negedge clock);
    check("sat_held", {sat, unsat}, {1'b1, 1'b0});
    check("sat_events_left", exp_q.size(), 0);
    exp_q.delete();

    // Decision x3=1 implies x5=0, which conflicts on channel 1; flip x3 and finish SAT.
    clear_tables();
    live[3] = 1'b1; live[5] = 1'b1;
    vse_s[3] = 10'd10; vse_e[3] = 10'd19;
    vse_s[5] = 10'd10; vse_e[5] = 10'd11;
    imp_v[7] = 1'b1; imp_var[7] = 8'd5; imp_val[7] = 1'b0;
    conf_mask[10] = 4'b0010;
    e_wr(3, 1, 0); e_push(3, 1, 1);
    e_bcp(4'b1111, {10'd19, 10'd19, 10'd16, 10'd18, 10'd13, 10'd15, 10'd10, 10'd12});
    e_wr(5, 0, 0); e_push(5, 0, 0); e_k(4'd4);
    e_bcp(4'b0011, {40'd0, 10'd11, 10'd11, 10'd10, 10'd10});
    e_k(4'd5);
    e_wr(5, 0, 1); e_k(4'd3);
    e_wr(3, 0, 0); e_k(4'd3);
    e_push(3, 0, 0);
    e_bcp(4'b1111, {10'd19, 10'd19, 10'd16, 10'd18, 10'd13, 10'd15, 10'd10, 10'd12});
    e_wr(5, 1, 0); e_push(5, 1, 1);
    e_bcp(4'b0011, {40'd0, 10'd11, 10'd11, 10'd10, 10'd10});
    e_k(4'd7);
    run("flip_sat", 1'b0, 1);

    // Single variable conflicting on both polarities: flip, unassign, UNSAT.
    clear_tables();
    live[2] = 1'b1; vse_s[2] = 10'd7; vse_e[2] = 10'd7;
    conf_mask[4] = 4'b0001; conf_mask[5] = 4'b0001;
    e_wr(2, 1, 0); e_push(2, 1, 1); e_bcp1(7); e_k(4'd5);
    e_wr(2, 0, 0); e_k(4'd3); e_push(2, 0, 0); e_bcp1(7); e_k(4'd5);
    e_wr(2, 0, 1); e_k(4'd3); e_k(4'd8);
    run("unsat", 1'b1, 2);

    // Variable with no clauses (end < start): no channel started, straight on to SAT.
    clear_tables();
    live[4] = 1'b1; vse_s[4] = 10'd5; vse_e[4] = 10'd4;
    e_wr(4, 1, 0); e_push(4, 1, 1); e_k(4'd7);
    run("empty_range", 1'b0, 0);

    // Four conflicts against a 2-bit counter: count sticks at 3.
    clear_tables();
    live[0] = 1'b1; live[1] = 1'b1;
    vse_s[0] = 10'd20; vse_e[0] = 10'd20; vse_s[1] = 10'd30; vse_e[1] = 10'd30;
    conf_mask[2] = 4'b0001; conf_mask[3] = 4'b0001;
    e_wr(0, 1, 0); e_push(0, 1, 1); e_bcp1(20);
    for (int r = 0; r < 2; r++) begin
      e_wr(1, 1, 0); e_push(1, 1, 1); e_bcp1(30); e_k(4'd5);
      e_wr(1, 0, 0); e_k(4'd3); e_push(1, 0, 0); e_bcp1(30); e_k(4'd5);
      e_wr(1, 0, 1); e_k(4'd3);
      if (r == 0) begin
        e_wr(0, 0, 0); e_k(4'd3); e_push(0, 0, 0); e_bcp1(20);
      end else begin
        e_wr(0, 0, 1); e_k(4'd3);
      end
    end
    e_k(4'd8);
    run("count_saturate", 1'b1, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
